// File: rtl/jk_cmd_arbiter.sv
// jk_cmd_arbiter: round-robin arbiter between two command requesters
// that drive the J/K inputs of a WIDTH-cell JK bank.
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   reqN_valid/op/mask      command from requester N (op: hold/clear/set/toggle)
//   reqN_ready              command from requester N accepted this cycle
//   j_out, k_out            J/K drive, non-zero only in EXEC
//   q, qn                   bank state and its inverse (one cycle behind)
//   busy, done              FSM not idle / one-cycle completion pulse
//   grant_id, cmd_count     requester in flight / completed-command count
module jk_cmd_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_mask,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_mask,
  output logic             req1_ready,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             busy,
  output logic             done,
  output logic             grant_id,
  output logic [7:0]       cmd_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SETTLE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] j_q;
  logic [WIDTH-1:0] k_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] qn_q;
  logic [WIDTH-1:0] q_d;
  logic             last_q;
  logic             gid_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       cnt_q;

  logic             any_v;
  logic             win;
  logic             acc;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] mask_sel;

  // Contest goes to the requester not granted last; a lone
  // valid always wins. Ready is held off while reset is high.
  always_comb begin
    any_v    = req0_valid | req1_valid;
    win      = (req0_valid & req1_valid) ? ~last_q : ~req0_valid;
    acc      = (state_q == IDLE) & any_v & ~reset;
    op_sel   = win ? req1_op : req0_op;
    mask_sel = win ? req1_mask : req0_mask;
  end

  // Per-cell JK next state from the latched drive.
  always_comb begin
    q_d = (~j_q & ~k_q & q_q)
        | ( j_q & ~k_q)
        | ( j_q &  k_q & ~q_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      j_q     <= '0;
      k_q     <= '0;
      q_q     <= '0;
      qn_q    <= '1;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      qn_q   <= ~q_q;
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            state_q <= EXEC;
            busy_q  <= 1'b1;
            // op[1] drives J (set/toggle), op[0] drives K (clear/toggle)
            j_q     <= mask_sel & {WIDTH{op_sel[1]}};
            k_q     <= mask_sel & {WIDTH{op_sel[0]}};
            gid_q   <= win;
            last_q  <= win;
          end
        end
        EXEC: begin
          state_q <= SETTLE;
          q_q     <= q_d;
          // qn must already match the new q during SETTLE
          qn_q    <= ~q_d;
          j_q     <= '0;
          k_q     <= '0;
          done_q  <= 1'b1;
          cnt_q   <= cnt_q + 8'd1;
        end
        SETTLE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = acc & ~win;
  assign req1_ready = acc & win;
  assign j_out      = j_q;
  assign k_out      = k_q;
  assign q          = q_q;
  assign qn         = qn_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign grant_id   = gid_q;
  assign cmd_count  = cnt_q;

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// tb_jk_cmd_arbiter: vector table plus scoreboard bench
// for the two-requester JK command arbiter.
module tb_jk_cmd_arbiter;

  logic       clk;
  logic       reset;
  logic       req0_valid;
  logic [1:0] req0_op;
  logic [7:0] req0_mask;
  logic       req0_ready;
  logic       req1_valid;
  logic [1:0] req1_op;
  logic [7:0] req1_mask;
  logic       req1_ready;
  logic [7:0] j_out;
  logic [7:0] k_out;
  logic [7:0] q;
  logic [7:0] qn;
  logic       busy;
  logic       done;
  logic       grant_id;
  logic [7:0] cmd_count;

  jk_cmd_arbiter #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .req0_valid(req0_valid),
    .req0_op(req0_op),
    .req0_mask(req0_mask),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_op(req1_op),
    .req1_mask(req1_mask),
    .req1_ready(req1_ready),
    .j_out(j_out),
    .k_out(k_out),
    .q(q),
    .qn(qn),
    .busy(busy),
    .done(done),
    .grant_id(grant_id),
    .cmd_count(cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         who;
    logic [1:0] op;
    logic [7:0] mask;
    logic [7:0] eq;
    logic [7:0] ej;
    logic [7:0] ek;
  } vec_t;

  typedef struct {
    logic       gid;
    logic [7:0] q;
    logic [7:0] qn;
    logic [7:0] cnt;
  } exp_t;

  int         n_cmp = 0;
  int         n_err = 0;
  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] q_m;
  logic [7:0] cnt_m;
  bit         last_m;
  vec_t       tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] jk_model(input logic [7:0] qi,
                                          input logic [1:0] op,
                                          input logic [7:0] m);
    logic [7:0] r;
    r = qi;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        case (op)
          2'b01:   r[i] = 1'b0;
          2'b10:   r[i] = 1'b1;
          2'b11:   r[i] = ~r[i];
          default: r[i] = r[i];
        endcase
      end
    end
    return r;
  endfunction

  // Completion monitor: every done pops one expected result.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL done_unexpected: got done=1 required 0");
        end else begin
          mon_e = sb.pop_front();
          chk("sb_q", 32'(q), 32'(mon_e.q));
          chk("sb_qn", 32'(qn), 32'(mon_e.qn));
          chk("sb_gid", 32'(grant_id), 32'(mon_e.gid));
          chk("sb_cnt", 32'(cmd_count), 32'(mon_e.cnt));
          chk("sb_busy", 32'(busy), 32'd1);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge where the
  // next command can be accepted.
  task automatic apply(input bit who, input logic [1:0] op,
                       input logic [7:0] mask, input logic [7:0] eq,
                       input logic [7:0] ej, input logic [7:0] ek);
    int w;
    req0_valid = !who;
    req1_valid = who;
    req0_op    = op;
    req1_op    = op;
    req0_mask  = mask;
    req1_mask  = mask;
    w = 0;
    #1;
    while (!(who ? req1_ready : req0_ready) && w < 8) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 8) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no ready required ready");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      return;
    end
    chk("accept_latency", 32'(w), 32'd0);
    cnt_m  = cnt_m + 8'd1;
    last_m = who;
    q_m    = eq;
    sb.push_back('{who, eq, ~eq, cnt_m});
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("exec_j", 32'(j_out), 32'(ej));
    chk("exec_k", 32'(k_out), 32'(ek));
    chk("exec_busy", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit         who;
    bit         ew;
    bit         d0;
    bit         d1;
    int         left0;
    int         left1;
    int         cyc;
    int         prev;
    logic [3:0] gseq;

    tbl[0] = '{1'b0, 2'b10, 8'h0F, 8'h0F, 8'h0F, 8'h00};
    tbl[1] = '{1'b1, 2'b11, 8'hFF, 8'hF0, 8'hFF, 8'hFF};
    tbl[2] = '{1'b0, 2'b10, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    tbl[3] = '{1'b0, 2'b01, 8'h81, 8'h7E, 8'h00, 8'h81};
    tbl[4] = '{1'b1, 2'b00, 8'hFF, 8'h7E, 8'h00, 8'h00};
    tbl[5] = '{1'b1, 2'b11, 8'h00, 8'h7E, 8'h00, 8'h00};
    tbl[6] = '{1'b0, 2'b11, 8'h3C, 8'h42, 8'h3C, 8'h3C};
    tbl[7] = '{1'b1, 2'b01, 8'h42, 8'h00, 8'h00, 8'h42};

    q_m    = 8'h00;
    cnt_m  = 8'h00;
    last_m = 1'b1;

    // Reset with both requesters valid: nothing may be granted.
    reset      = 1'b1;
    req0_valid = 1'b1;
    req0_op    = 2'b10;
    req0_mask  = 8'hFF;
    req1_valid = 1'b1;
    req1_op    = 2'b11;
    req1_mask  = 8'hFF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_qn", 32'(qn), 32'hFF);
    chk("rst_j", 32'(j_out), 32'h00);
    chk("rst_k", 32'(k_out), 32'h00);
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_cnt", 32'(cmd_count), 32'd0);

    // Release and present the first vector in the same cycle.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].who, tbl[i].op, tbl[i].mask,
            tbl[i].eq, tbl[i].ej, tbl[i].ek);
    end
    chk("idle_busy", 32'(busy), 32'd0);

    // Both valid, two commands each: grants alternate.
    req0_valid = 1'b1;
    req0_op    = 2'b10;
    req0_mask  = 8'h01;
    req1_valid = 1'b1;
    req1_op    = 2'b11;
    req1_mask  = 8'h02;
    left0 = 2;
    left1 = 2;
    cyc   = 0;
    prev  = -1;
    gseq  = 4'h0;
    d0    = 1'b0;
    d1    = 1'b0;
    while ((left0 > 0 || left1 > 0) && cyc < 40) begin
      #1;
      if (req0_ready || req1_ready) begin
        who = req1_ready;
        ew  = (req0_valid && req1_valid) ? ~last_m : req1_valid;
        chk("rr_grant", 32'(who), 32'(ew));
        if (prev >= 0) chk("rr_spacing", 32'(cyc - prev), 32'd3);
        prev = cyc;
        gseq = {gseq[2:0], who};
        q_m  = jk_model(q_m, who ? req1_op : req0_op,
                        who ? req1_mask : req0_mask);
        cnt_m  = cnt_m + 8'd1;
        last_m = who;
        sb.push_back('{who, q_m, ~q_m, cnt_m});
        if (who) begin
          left1--;
          d1 = (left1 == 0);
        end else begin
          left0--;
          d0 = (left0 == 0);
        end
      end
      @(negedge clk);
      cyc++;
      if (d0) begin
        req0_valid = 1'b0;
        d0 = 1'b0;
      end
      if (d1) begin
        req1_valid = 1'b0;
        d1 = 1'b0;
      end
    end
    if (left0 > 0 || left1 > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL rr_timeout: got %0d left required 0",
               left0 + left1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_order", 32'(gseq), 32'h5);
    repeat (2) @(negedge clk);

    // Reset during EXEC aborts the command; request is held.
    req0_valid = 1'b1;
    req0_op    = 2'b10;
    req0_mask  = 8'hFF;
    #1;
    chk("abort_rdy", 32'(req0_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_qn", 32'(qn), 32'hFF);
    chk("abort_cnt", 32'(cmd_count), 32'd0);
    chk("abort_j", 32'(j_out), 32'h00);
    @(negedge clk);
    #1;
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rdy_rst", 32'(req0_ready), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    sb.delete();
    q_m    = 8'h00;
    cnt_m  = 8'h00;
    last_m = 1'b1;
    apply(1'b0, 2'b10, 8'hFF, 8'hFF, 8'hFF, 8'h00);

    // Counter wrap: 255 more commands bring it from 1 to 0.
    for (int i = 0; i < 255; i++) begin
      apply(i[0], 2'b00, 8'h00, q_m, 8'h00, 8'h00);
    end
    chk("cnt_wrap", 32'(cmd_count), 32'd0);
    chk("wrap_q", 32'(q), 32'hFF);

    repeat (2) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jk_cmd_arbiter.md
JK_CMD_ARBITER -- requirements
Module: jk_cmd_arbiter

Interface
REQ-001 Parameter WIDTH, 8, number of JK cells in the controlled bank (2..32).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 command valid.
REQ-005 req0_op  input  2  requester 0 opcode: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-006 req0_mask  input  WIDTH  requester 0 cell select; 1 = cell affected.
REQ-007 req0_ready  output  1  requester 0 command accepted this cycle.
REQ-008 req1_valid, req1_op, req1_mask, req1_ready  same widths and meaning as requester 0, for requester 1.
REQ-009 j_out  output  WIDTH  J inputs driven to the bank.
REQ-010 k_out  output  WIDTH  K inputs driven to the bank.
REQ-011 q  output  WIDTH  bank state.
REQ-012 qn  output  WIDTH  inverted bank state, one cycle behind q.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.
REQ-014 done  output  1  one-cycle pulse on command completion.
REQ-015 grant_id  output  1  requester whose command is in flight; holds last value in IDLE.
REQ-016 cmd_count  output  8  completed-command counter.

Function
REQ-017 FSM states: IDLE, EXEC, SETTLE; no other states reachable.
REQ-018 IDLE: if any valid, select a winner, assert exactly that requester's ready for one cycle, latch its op/mask, and go to EXEC; otherwise stay in IDLE.
REQ-019 Handshake: a transfer occurs only when valid and ready are both high; ready is never high outside IDLE; ready never goes to both requesters in the same cycle.
REQ-020 Arbitration: single valid wins; both valid -> the requester not granted last wins (round-robin); last-grant pointer resets to 1, so requester 0 wins the first contest.
REQ-021 EXEC: for each masked cell, drive j_out/k_out per opcode: hold 0/0, clear 0/1, set 1/0, toggle 1/1; unmasked cells 0/0. Outside EXEC, j_out = k_out = 0.
REQ-022 Bank update at the clock edge ending EXEC, per cell: J=0,K=0 keep; 0,1 -> 0; 1,0 -> 1; 1,1 -> invert.
REQ-023 SETTLE: qn becomes ~q (the value q took at the end of EXEC); assert done; increment cmd_count modulo 256 (255 -> 0); go to IDLE.
REQ-024 Outside SETTLE, qn keeps tracking ~q with one-cycle lag; done = 0.
REQ-025 Latency: accept at cycle N, j/k driven in N+1, q updated after edge N+1, done and qn valid in N+2, next accept no earlier than N+3.
REQ-026 Hold opcode and all-zero mask still run the full EXEC/SETTLE sequence, pulse done, and increment cmd_count; q does not change.
REQ-027 busy = 1 in EXEC and SETTLE, 0 in IDLE.
REQ-028 Inputs from a requester are ignored while its ready is low; a request held valid stays pending without loss until accepted.

Reset
REQ-029 While reset is high: state IDLE; q = 0; qn = all ones; j_out = k_out = 0; ready outputs 0; busy = 0; done = 0; grant_id = 0; cmd_count = 0; last-grant pointer = 1.
REQ-030 Reset asserted in EXEC or SETTLE aborts the command with no q update, done pulse or count increment; the aborted requester must re-present its request.
REQ-031 First acceptance possible in the first clock edge after reset deasserts.

Verification
REQ-032 After reset, req0 set, mask 0x0F -> req0_ready at N, j_out=0x0F and k_out=0 at N+1, q=0x0F and done=1 and qn=0xF0 at N+2, cmd_count=1.
REQ-033 q=0x0F, req1 toggle, mask 0xFF -> q=0xF0, grant_id=1, done once, cmd_count increments by 1.
REQ-034 Both valid continuously with four commands queued -> grants alternate 0,1,0,1; one accept per 3 cycles; never both ready in a cycle.
REQ-035 q=0xFF, req0 clear, mask 0x81 -> q=0x7E; then hold, mask 0xFF -> q stays 0x7E with done pulsed.
REQ-036 Reset asserted during EXEC of set, mask 0xFF -> q=0, qn=0xFF, no done, cmd_count=0; request re-granted after release.
REQ-037 256 completed commands -> cmd_count wraps to 0.
